// File: rtl/cpu_pkg.sv
// Shared types and constants for the CPU control unit: state encodings,
// opcode map, instruction classes and instruction-word field positions.
package cpu_pkg;

    typedef enum logic [3:0] {
        ST_RESET    = 4'd0,
        ST_FETCH    = 4'd1,
        ST_DECODE   = 4'd2,
        ST_EXEC_ALU = 4'd3,
        ST_LOAD     = 4'd4,
        ST_STORE    = 4'd5,
        ST_JUMP     = 4'd6,
        ST_HALT     = 4'd7,
        ST_ILLEGAL  = 4'd8
    } state_e;

    typedef enum logic [3:0] {
        CLS_NOP,
        CLS_ALU,
        CLS_LD,
        CLS_ST,
        CLS_JMP,
        CLS_JZ,
        CLS_JN,
        CLS_HALT,
        CLS_ILLEGAL
    } instr_class_e;

    typedef struct packed {
        logic c;
        logic n;
        logic z;
    } flags_t;

    localparam logic [6:0] OP_NOP  = 7'h00;
    localparam logic [6:0] OP_LD   = 7'h20;
    localparam logic [6:0] OP_ST   = 7'h21;
    localparam logic [6:0] OP_JMP  = 7'h30;
    localparam logic [6:0] OP_JZ   = 7'h31;
    localparam logic [6:0] OP_JN   = 7'h32;
    localparam logic [6:0] OP_HALT = 7'h3F;

    // ALU opcodes occupy 7'h10-7'h1F; the low nibble is the ALU operation.
    localparam logic [2:0] OP_ALU_HI = 3'b001;

    localparam logic [3:0] ALU_PASS_R = 4'h0;

    localparam int OP_MSB = 15;
    localparam int OP_LSB = 9;
    localparam int WA_MSB = 8;
    localparam int WA_LSB = 6;
    localparam int RA_MSB = 5;
    localparam int RA_LSB = 3;
    localparam int SA_MSB = 2;
    localparam int SA_LSB = 0;

endpackage

// File: rtl/cpu_control_unit_if.sv
// Control-unit <-> execution-unit bundle: EU status into the control unit,
// every EU control strobe and register address out of it.
interface cpu_control_unit_if;
    import cpu_pkg::*;

    logic [15:0] ir;
    logic        c;
    logic        n;
    logic        z;

    logic [2:0]  w_adr;
    logic [2:0]  r_adr;
    logic [2:0]  s_adr;
    logic [3:0]  alu_op;
    logic        s_sel;
    logic        ds;
    logic        reg_w_en;
    logic        pc_ld;
    logic        pc_inc;
    logic        ir_ld;
    logic        adr_sel;
    logic        mem_r_en;
    logic        mem_w_en;
    logic        halted;
    logic [3:0]  state;

    modport master (
        input  ir, c, n, z,
        output w_adr, r_adr, s_adr, alu_op, s_sel, ds, reg_w_en,
               pc_ld, pc_inc, ir_ld, adr_sel, mem_r_en, mem_w_en,
               halted, state
    );

    modport slave (
        output ir, c, n, z,
        input  w_adr, r_adr, s_adr, alu_op, s_sel, ds, reg_w_en,
               pc_ld, pc_inc, ir_ld, adr_sel, mem_r_en, mem_w_en,
               halted, state
    );

endinterface

// File: rtl/cpu_control_unit_decoder.sv
// Combinational opcode classifier: maps the 7-bit opcode to an instruction
// class and flags whether the opcode is defined at all.
module cu_decoder
    import cpu_pkg::*;
(
    input  logic [6:0]   op_i,
    output instr_class_e cls_o,
    output logic         legal_o
);

    always_comb begin
        cls_o = CLS_ILLEGAL;
        if (op_i[6:4] == OP_ALU_HI) begin
            cls_o = CLS_ALU;
        end else begin
            case (op_i)
                OP_NOP:  cls_o = CLS_NOP;
                OP_LD:   cls_o = CLS_LD;
                OP_ST:   cls_o = CLS_ST;
                OP_JMP:  cls_o = CLS_JMP;
                OP_JZ:   cls_o = CLS_JZ;
                OP_JN:   cls_o = CLS_JN;
                OP_HALT: cls_o = CLS_HALT;
                default: cls_o = CLS_ILLEGAL;
            endcase
        end
    end

    assign legal_o = (cls_o != CLS_ILLEGAL);

endmodule

// File: rtl/cpu_control_unit.sv
// Multi-cycle Moore control FSM for the 16-bit CPU: sequences fetch/decode/
// execute, drives every EU control input and holds the branch flag register.
module cpu_control_unit
    import cpu_pkg::*;
#(
    parameter bit HALT_ON_ILLEGAL = 1'b1
) (
    input  logic               clk,
    input  logic               reset,
    cpu_control_unit_if.master bus
);

    state_e       state_q, state_d;
    flags_t       flags_q;
    instr_class_e cls;
    logic         legal;

    logic [6:0] op;
    logic [2:0] wa, ra, sa;

    assign op = bus.ir[OP_MSB:OP_LSB];
    assign wa = bus.ir[WA_MSB:WA_LSB];
    assign ra = bus.ir[RA_MSB:RA_LSB];
    assign sa = bus.ir[SA_MSB:SA_LSB];

    cu_decoder u_decoder (
        .op_i    (op),
        .cls_o   (cls),
        .legal_o (legal)
    );

    // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d = ST_RESET;
        case (state_q)
            ST_RESET:  state_d = ST_FETCH;
            ST_FETCH:  state_d = ST_DECODE;
            ST_DECODE: begin
                if (!legal) begin
                    state_d = HALT_ON_ILLEGAL ? ST_ILLEGAL : ST_FETCH;
                end else begin
                    case (cls)
                        CLS_ALU:  state_d = ST_EXEC_ALU;
                        CLS_LD:   state_d = ST_LOAD;
                        CLS_ST:   state_d = ST_STORE;
                        CLS_JMP:  state_d = ST_JUMP;
                        // Conditional branches test the latched flags, never live c/n/z.
                        CLS_JZ:   state_d = flags_q.z ? ST_JUMP : ST_FETCH;
                        CLS_JN:   state_d = flags_q.n ? ST_JUMP : ST_FETCH;
                        CLS_HALT: state_d = ST_HALT;
                        default:  state_d = ST_FETCH;
                    endcase
                end
            end
            ST_EXEC_ALU, ST_LOAD, ST_STORE, ST_JUMP: state_d = ST_FETCH;
            ST_HALT:    state_d = ST_HALT;
            ST_ILLEGAL: state_d = ST_ILLEGAL;
            default:    state_d = ST_RESET;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_RESET;
            flags_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_EXEC_ALU) begin
                flags_q <= '{c: bus.c, n: bus.n, z: bus.z};
            end
        end
    end

    always_comb begin
        bus.w_adr    = '0;
        bus.r_adr    = '0;
        bus.s_adr    = '0;
        bus.alu_op   = '0;
        bus.s_sel    = 1'b0;
        bus.ds       = 1'b0;
        bus.reg_w_en = 1'b0;
        bus.pc_ld    = 1'b0;
        bus.pc_inc   = 1'b0;
        bus.ir_ld    = 1'b0;
        bus.adr_sel  = 1'b0;
        bus.mem_r_en = 1'b0;
        bus.mem_w_en = 1'b0;
        bus.halted   = 1'b0;
        bus.state    = state_q;

        if (state_q inside {ST_DECODE, ST_EXEC_ALU, ST_LOAD, ST_STORE, ST_JUMP}) begin
            bus.w_adr = wa;
            bus.r_adr = ra;
            bus.s_adr = sa;
        end

        case (state_q)
            ST_FETCH: begin
                bus.mem_r_en = 1'b1;
                bus.ir_ld    = 1'b1;
                bus.pc_inc   = 1'b1;
            end
            ST_EXEC_ALU: begin
                bus.alu_op   = op[3:0];
                bus.reg_w_en = 1'b1;
            end
            ST_LOAD: begin
                bus.adr_sel  = 1'b1;
                bus.mem_r_en = 1'b1;
                bus.ds       = 1'b1;
                bus.reg_w_en = 1'b1;
            end
            ST_STORE: begin
                bus.adr_sel  = 1'b1;
                bus.mem_w_en = 1'b1;
            end
            ST_JUMP: begin
                bus.alu_op = ALU_PASS_R;
                bus.pc_ld  = 1'b1;
            end
            ST_HALT, ST_ILLEGAL: bus.halted = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_cpu_control_unit.sv
// Bench for cpu_control_unit: two instances (halt-on-illegal and treat-as-NOP)
// compared cycle by cycle against an instruction-level behavioural model.
module tb_cpu_control_unit;

    typedef struct packed {
        logic [2:0] w_adr;
        logic [2:0] r_adr;
        logic [2:0] s_adr;
        logic [3:0] alu_op;
        logic       s_sel;
        logic       ds;
        logic       reg_w_en;
        logic       pc_ld;
        logic       pc_inc;
        logic       ir_ld;
        logic       adr_sel;
        logic       mem_r_en;
        logic       mem_w_en;
        logic       halted;
        logic [3:0] state;
    } ctl_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] ir_drv;
    logic        c_drv, n_drv, z_drv;

    int errors = 0;
    int checks = 0;

    // Model state: latched branch flags and expected per-cycle control vectors.
    logic mz, mn;
    ctl_t exp_h[$];
    ctl_t exp_n[$];

    always #5 clk = ~clk;

    cpu_control_unit_if bus_h ();
    cpu_control_unit_if bus_n ();

    assign bus_h.ir = ir_drv;
    assign bus_h.c  = c_drv;
    assign bus_h.n  = n_drv;
    assign bus_h.z  = z_drv;
    assign bus_n.ir = ir_drv;
    assign bus_n.c  = c_drv;
    assign bus_n.n  = n_drv;
    assign bus_n.z  = z_drv;

    cpu_control_unit #(.HALT_ON_ILLEGAL(1'b1)) dut_h (.clk(clk), .reset(reset), .bus(bus_h));
    cpu_control_unit #(.HALT_ON_ILLEGAL(1'b0)) dut_n (.clk(clk), .reset(reset), .bus(bus_n));

    ctl_t obs_h, obs_n;
    assign obs_h = {bus_h.w_adr, bus_h.r_adr, bus_h.s_adr, bus_h.alu_op, bus_h.s_sel, bus_h.ds,
                    bus_h.reg_w_en, bus_h.pc_ld, bus_h.pc_inc, bus_h.ir_ld, bus_h.adr_sel,
                    bus_h.mem_r_en, bus_h.mem_w_en, bus_h.halted, bus_h.state};
    assign obs_n = {bus_n.w_adr, bus_n.r_adr, bus_n.s_adr, bus_n.alu_op, bus_n.s_sel, bus_n.ds,
                    bus_n.reg_w_en, bus_n.pc_ld, bus_n.pc_inc, bus_n.ir_ld, bus_n.adr_sel,
                    bus_n.mem_r_en, bus_n.mem_w_en, bus_n.halted, bus_n.state};

    function automatic ctl_t vec(input logic [3:0] st);
        ctl_t v = '0;
        v.state = st;
        return v;
    endfunction

    function automatic ctl_t fetch_v();
        ctl_t v = vec(4'd1);
        v.ir_ld    = 1'b1;
        v.pc_inc   = 1'b1;
        v.mem_r_en = 1'b1;
        return v;
    endfunction

    function automatic ctl_t fields_v(input logic [3:0] st, input logic [15:0] i);
        ctl_t v = vec(st);
        v.w_adr = i[8:6];
        v.r_adr = i[5:3];
        v.s_adr = i[2:0];
        return v;
    endfunction

    // Expected control sequence of one instruction, starting at its fetch cycle.
    task automatic model_instr(input logic [15:0] i);
        logic [6:0] op = i[15:9];
        ctl_t x = fields_v(4'd2, i);
        bit   has_x = 1'b1;
        bit   illegal = 1'b0;
        bit   is_alu = (op >= 7'h10 && op <= 7'h1F);
        if (is_alu) begin
            x.state = 4'd3; x.alu_op = op[3:0]; x.reg_w_en = 1'b1;
        end else if (op == 7'h20) begin
            x.state = 4'd4; x.adr_sel = 1'b1; x.mem_r_en = 1'b1; x.ds = 1'b1; x.reg_w_en = 1'b1;
        end else if (op == 7'h21) begin
            x.state = 4'd5; x.adr_sel = 1'b1; x.mem_w_en = 1'b1;
        end else if (op == 7'h30 || (op == 7'h31 && mz) || (op == 7'h32 && mn)) begin
            x.state = 4'd6; x.pc_ld = 1'b1; x.alu_op = 4'h0;
        end else if (op == 7'h00 || op == 7'h31 || op == 7'h32) begin
            has_x = 1'b0;
        end else if (op == 7'h3F) begin
            x = vec(4'd7); x.halted = 1'b1;
        end else begin
            illegal = 1'b1;
        end
        exp_h.push_back(fetch_v());
        exp_n.push_back(fetch_v());
        exp_h.push_back(fields_v(4'd2, i));
        exp_n.push_back(fields_v(4'd2, i));
        if (illegal) begin
            x = vec(4'd8); x.halted = 1'b1;
            exp_h.push_back(x);
        end else if (has_x) begin
            exp_h.push_back(x);
            exp_n.push_back(x);
        end
        if (is_alu) begin
            mn = n_drv;
            mz = z_drv;
        end
    endtask

    task automatic test_reset();
        ctl_t e;
        reset = 1'b1; ir_drv = 16'h2053; c_drv = 1'b1; n_drv = 1'b1; z_drv = 1'b1;
        repeat (2) begin
            @(posedge clk); #1;
            checks++;
            if (obs_h !== '0) begin errors++; $display("FAIL reset_h got=%h exp=0", obs_h); end
            checks++;
            if (obs_n !== '0) begin errors++; $display("FAIL reset_n got=%h exp=0", obs_n); end
        end
        reset = 1'b0; mz = 1'b0; mn = 1'b0;
        @(posedge clk); #1;
        e = fetch_v();
        checks++;
        if (obs_h !== e) begin errors++; $display("FAIL first_fetch got=%h exp=%h", obs_h, e); end
    endtask

    task automatic test_alu();
        ctl_t e;
        ir_drv = 16'h2053; c_drv = 1'b0; n_drv = 1'b0; z_drv = 1'b1;
        @(posedge clk); #1;
        e = vec(4'd2); e.w_adr = 3'd1; e.r_adr = 3'd2; e.s_adr = 3'd3;
        checks++;
        if (obs_h !== e) begin errors++; $display("FAIL alu_decode got=%h exp=%h", obs_h, e); end
        @(posedge clk); #1;
        e.state = 4'd3; e.reg_w_en = 1'b1; e.alu_op = 4'h0;
        checks++;
        if (obs_h !== e) begin errors++; $display("FAIL alu_exec got=%h exp=%h", obs_h, e); end
        @(posedge clk); #1;
        e = fetch_v();
        checks++;
        if (obs_h !== e) begin errors++; $display("FAIL alu_latency got=%h exp=%h", obs_h, e); end
        mz = 1'b1; mn = 1'b0;
    endtask

    task automatic test_branch();
        ctl_t e;
        // Taken: latched Z=1, live z=0.
        ir_drv = 16'h6208; z_drv = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        e = vec(4'd6); e.r_adr = 3'd1; e.pc_ld = 1'b1;
        checks++;
        if (obs_h !== e) begin errors++; $display("FAIL jz_taken got=%h exp=%h", obs_h, e); end
        @(posedge clk); #1;
        e = fetch_v();
        checks++;
        if (obs_h !== e) begin errors++; $display("FAIL jz_taken_ret got=%h exp=%h", obs_h, e); end
        // Clear Z through an ALU op, then branch with live z=1.
        ir_drv = 16'h2053; z_drv = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        ir_drv = 16'h6208; z_drv = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        e = fetch_v();
        checks++;
        if (obs_h !== e) begin errors++; $display("FAIL jz_not_taken got=%h exp=%h", obs_h, e); end
        mz = 1'b0;
    endtask

    task automatic test_store_reset();
        ctl_t e;
        ir_drv = 16'h4211;
        @(posedge clk); #1;
        @(posedge clk); #1;
        e = vec(4'd5); e.r_adr = 3'd2; e.s_adr = 3'd1; e.adr_sel = 1'b1; e.mem_w_en = 1'b1;
        checks++;
        if (obs_h !== e) begin errors++; $display("FAIL store got=%h exp=%h", obs_h, e); end
        reset = 1'b1;
        repeat (2) begin
            @(posedge clk); #1;
            checks++;
            if (obs_h !== '0) begin errors++; $display("FAIL store_reset got=%h exp=0", obs_h); end
        end
        reset = 1'b0; mz = 1'b0; mn = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        int   sel;
        logic [6:0] op;
        for (int t = 0; t < 40; t++) begin
            sel = int'($urandom_range(0, 6));
            case (sel)
                0:       op = 7'h00;
                1:       op = 7'h10 + 7'($urandom_range(0, 15));
                2:       op = 7'h20;
                3:       op = 7'h21;
                4:       op = 7'h30;
                5:       op = 7'h31;
                default: op = 7'h32;
            endcase
            ir_drv = {op, 9'($urandom)};
            c_drv = 1'($urandom); n_drv = 1'($urandom); z_drv = 1'($urandom);
            model_instr(ir_drv);
            for (int k = 0; k < exp_h.size(); k++) begin
                #1;
                checks++;
                if (obs_h !== exp_h[k]) begin
                    errors++; $display("FAIL rand_h ir=%h cyc=%0d got=%h exp=%h", ir_drv, k, obs_h, exp_h[k]);
                end
                checks++;
                if (obs_n !== exp_n[k]) begin
                    errors++; $display("FAIL rand_n ir=%h cyc=%0d got=%h exp=%h", ir_drv, k, obs_n, exp_n[k]);
                end
                @(posedge clk); #1;
            end
            exp_h.delete();
            exp_n.delete();
        end
    endtask

    task automatic test_halt();
        ctl_t e;
        ir_drv = 16'h7E00;
        @(posedge clk); #1;
        @(posedge clk); #1;
        e = vec(4'd7); e.halted = 1'b1;
        for (int k = 0; k < 20; k++) begin
            c_drv = 1'($urandom); n_drv = 1'($urandom); z_drv = 1'($urandom);
            #1;
            checks++;
            if (obs_h !== e) begin errors++; $display("FAIL halt cyc=%0d got=%h exp=%h", k, obs_h, e); end
            @(posedge clk); #1;
        end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0; mz = 1'b0; mn = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_illegal();
        ctl_t e;
        ir_drv = 16'h0400;
        @(posedge clk); #1;
        @(posedge clk); #1;
        e = fetch_v();
        checks++;
        if (obs_n !== e) begin errors++; $display("FAIL illegal_as_nop got=%h exp=%h", obs_n, e); end
        e = vec(4'd8); e.halted = 1'b1;
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (obs_h !== e) begin errors++; $display("FAIL illegal cyc=%0d got=%h exp=%h", k, obs_h, e); end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_branch();
        test_store_reset();
        test_random();
        test_halt();
        test_illegal();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cpu_control_unit.md
Name: cpu_control_unit

Overview:
- Multi-cycle Moore control FSM that sits directly upstream of the CPU execution unit and drives every EU control input.
- Each cycle it observes the EU instruction register output and the ALU status flags.
- It sequences fetch, decode and execute for a 16-bit single-address-space CPU.
- It also holds the architectural flag register used by conditional branches.

Parameters:
- HALT_ON_ILLEGAL, 1, 1 = an undefined opcode enters ILLEGAL (sticky); 0 = it is treated as NOP.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high
- ir  in  16  EU instruction register output
- c  in  1  ALU carry, same-cycle
- n  in  1  ALU negative, same-cycle
- z  in  1  ALU zero, same-cycle
- w_adr  out  3  register-file write address
- r_adr  out  3  register-file R read address
- s_adr  out  3  register-file S read address
- alu_op  out  4  ALU operation select
- s_sel  out  1  ALU S-operand mux select (0 = register S)
- ds  out  1  write-back data select (0 = ALU, 1 = memory Din)
- reg_w_en  out  1  register-file write enable
- pc_ld  out  1  load PC from ALU output
- pc_inc  out  1  increment PC
- ir_ld  out  1  load IR from Din
- adr_sel  out  1  memory address select (0 = PC, 1 = reg_out)
- mem_r_en  out  1  memory read strobe
- mem_w_en  out  1  memory write strobe
- halted  out  1  1 in HALT or ILLEGAL
- state  out  4  current state encoding (debug)

Behaviour:
- Clocking and reset:
  - One clock domain, clk. reset is synchronous and active-high.
  - At a rising edge with reset=1: state <= RESET, flags {C,N,Z} <= 0.
  - In RESET, all outputs are 0. This holds for reset asserted in any state, including mid-STORE; mem_w_en is 0 in the cycle after that edge.
- Output model:
  - All outputs are combinational functions of the registered state and ir. No output depends on c/n/z except via latched flags.
  - Any control output not listed for a state is 0.
- Instruction fields:
  - op = ir[15:9], wa = ir[8:6], ra = ir[5:3], sa = ir[2:0].
  - In DECODE and all execute states: w_adr=wa, r_adr=ra, s_adr=sa.
- Opcodes (package constants):
  - NOP 7'h00
  - ALU 7'h10-7'h1F, alu_op = op[3:0]
  - LD 7'h20
  - ST 7'h21
  - JMP 7'h30
  - JZ 7'h31
  - JN 7'h32
  - HALT 7'h3F
  - everything else is illegal.
- States and transitions:
  - RESET: -> FETCH.
  - FETCH: adr_sel=0, mem_r_en=1, ir_ld=1, pc_inc=1 -> DECODE.
  - DECODE: no strobes; dispatch on ir:
    - NOP -> FETCH
    - ALU -> EXEC_ALU
    - LD -> LOAD
    - ST -> STORE
    - JMP -> JUMP
    - JZ -> JUMP if flag Z=1, else -> FETCH
    - JN -> JUMP if flag N=1, else -> FETCH
    - HALT -> HALT
    - illegal -> ILLEGAL (HALT_ON_ILLEGAL=1) or FETCH (=0).
  - EXEC_ALU: alu_op=op[3:0], s_sel=0, ds=0, reg_w_en=1. Flags <= {c,n,z} at the end of this cycle. -> FETCH.
  - LOAD: adr_sel=1, mem_r_en=1, ds=1, reg_w_en=1. Flags unchanged. -> FETCH.
  - STORE: adr_sel=1, mem_w_en=1, s_adr=sa (data). -> FETCH.
  - JUMP: alu_op=ALU_PASS_R (4'h0), pc_ld=1 (target = R). -> FETCH.
  - HALT, ILLEGAL: halted=1, no strobes; remain until reset.
- Latency:
  - 3 cycles: ALU, LD, ST, taken branch.
  - 2 cycles: NOP, untaken branch.
- Invariants:
  - pc_ld and pc_inc are never both 1.
  - mem_r_en and mem_w_en are never both 1.
  - reg_w_en=1 only in EXEC_ALU and LOAD.
- Flag timing: flags used by JZ/JN are those from the most recent EXEC_ALU, never the live c/n/z.
- Unreachable state encodings -> RESET on the next edge.

Decomposition:
- Package cpu_pkg holds:
  - state encodings (RESET=0, FETCH=1, DECODE=2, EXEC_ALU=3, LOAD=4, STORE=5, JUMP=6, HALT=7, ILLEGAL=8)
  - opcode constants
  - ALU_PASS_R
  - field position constants.
- One natural sub-module: cu_decoder, a combinational op -> instruction class plus legal bit. The FSM and flag register stay in the top.

Test Plan:
- reset=1 for 2 cycles, then 0 -> outputs all 0 during reset; state RESET, then FETCH on the next edge with ir_ld=pc_inc=mem_r_en=1.
- ir=16'h2053 (ALU op 0x10, wa=1, ra=2, sa=3), z=1 during EXEC_ALU -> reg_w_en=1 exactly one cycle, w_adr=1, r_adr=2, s_adr=3, alu_op=0; flag Z=1 latched; back to FETCH after 3 cycles.
- Branch-taken path:
  - Stimulus: after the above, ir=16'h6208 (JZ, ra=1); live z=0 during DECODE.
  - Response: JUMP taken using latched Z=1; pc_ld=1 one cycle with alu_op=0, pc_inc=0.
- Branch-not-taken path:
  - Stimulus: repeat with latched Z=0.
  - Response: FETCH directly after DECODE, no pc_ld.
- ir=16'h4211 (ST, ra=2, sa=1), reset asserted during STORE -> mem_w_en=1 then 0 after the reset edge; no second write; state=RESET.
- Halt and illegal handling:
  - ir=16'h7E00 (HALT) -> halted=1, no strobes for 20 cycles, state stuck at HALT.
  - ir=16'h0400 (op 0x02) -> ILLEGAL, halted=1.
  - With HALT_ON_ILLEGAL=0, the same ir=16'h0400 returns to FETCH.
